// File: rtl/bf_mem_pkg.sv
// Shared constants for the BrainFuzz program/data memory pair:
// bus widths, opcode encodings and the fixed program image.
package bf_mem_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 2 ** ADDR_W;

  localparam logic [DATA_W-1:0] OP_INC   = 8'h2B;
  localparam logic [DATA_W-1:0] OP_DEC   = 8'h2D;
  localparam logic [DATA_W-1:0] OP_RIGHT = 8'h3E;
  localparam logic [DATA_W-1:0] OP_LEFT  = 8'h3C;
  localparam logic [DATA_W-1:0] OP_LOOP  = 8'h5B;
  localparam logic [DATA_W-1:0] OP_END   = 8'h5D;
  localparam logic [DATA_W-1:0] OP_OUT   = 8'h2E;
  localparam logic [DATA_W-1:0] OP_IN    = 8'h2C;
  localparam logic [DATA_W-1:0] OP_HALT  = 8'h00;

  typedef logic [DATA_W-1:0] rom_image_t [0:DEPTH-1];

  // "+++[>++<-]>." followed by halt markers in the unused tail.
  localparam rom_image_t ROM_IMAGE = '{
    OP_INC, OP_INC, OP_INC, OP_LOOP,
    OP_RIGHT, OP_INC, OP_INC, OP_LEFT,
    OP_DEC, OP_END, OP_RIGHT, OP_OUT,
    OP_HALT, OP_HALT, OP_HALT, OP_HALT
  };

endpackage

// File: rtl/rom_ram_chip_if.sv
// Address and control strobes that the interpreter core drives into the memory pair.
interface rom_ram_chip_if;
  import bf_mem_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              rom_ce_n;
  logic              ram_ce_n;
  logic              ram_we_n;
  logic              ram_oe_n;

  modport master (
    output address,
    output rom_ce_n,
    output ram_ce_n,
    output ram_we_n,
    output ram_oe_n
  );

  modport slave (
    input address,
    input rom_ce_n,
    input ram_ce_n,
    input ram_we_n,
    input ram_oe_n
  );

endinterface

// File: rtl/bf_rom.sv
// Fixed program store: combinational lookup that drives the shared bus only while selected.
module bf_rom
  import bf_mem_pkg::*;
(
  input  logic [ADDR_W-1:0] address,
  input  logic              rom_ce_n,
  inout  wire  [DATA_W-1:0] data
);

  logic [DATA_W-1:0] rom_word;

  assign rom_word = ROM_IMAGE[address];
  assign data     = rom_ce_n ? {DATA_W{1'bz}} : rom_word;

endmodule

// File: rtl/rom_ram_chip.sv
// BrainFuzz program ROM plus async-style data SRAM sharing one address bus and one tri-state data bus.
module rom_ram_chip
  import bf_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  rom_ram_chip_if.slave     bus,
  inout  wire  [DATA_W-1:0] data
);

  logic [DATA_W-1:0] ram [0:DEPTH-1];
  logic              ram_wr;
  logic              ram_rd;
  logic [DATA_W-1:0] ram_word;

  bf_rom u_rom (
    .address  (bus.address),
    .rom_ce_n (bus.rom_ce_n),
    .data     (data)
  );

  assign ram_wr = !bus.ram_ce_n && !bus.ram_we_n;

  // The ROM wins the bus and a write cycle never reads, so at most one block driver is active.
  assign ram_rd = rst_n && !bus.ram_ce_n && !bus.ram_oe_n && bus.ram_we_n && bus.rom_ce_n;

  // Write data is whatever the bus resolves to, so with the ROM selected this copies the ROM word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ram[i] <= '0;
      end
    end else if (ram_wr) begin
      ram[bus.address] <= data;
    end
  end

  assign ram_word = ram[bus.address];
  assign data     = ram_rd ? ram_word : {DATA_W{1'bz}};

endmodule

// File: tb/tb_rom_ram_chip.sv
// Directed bench for rom_ram_chip: ROM image, RAM read/write, ROM priority, copy and async reset.
module tb_rom_ram_chip;
  import bf_mem_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rom_ram_chip_if bus ();

  wire  [DATA_W-1:0] data;
  logic              tb_oe;
  logic [DATA_W-1:0] tb_wdata;

  assign data = tb_oe ? tb_wdata : {DATA_W{1'bz}};

  // A released bus reads back as all ones.
  for (genvar i = 0; i < DATA_W; i++) begin : g_pu
    pullup (data[i]);
  end

  localparam logic [DATA_W-1:0] RELEASED = 8'hFF;

  rom_ram_chip dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .data  (data)
  );

  // scoreboard
  logic [DATA_W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic push_exp(input logic [DATA_W-1:0] exp);
    exp_q.push_back(exp);
  endtask

  task automatic check_bus(input string tag);
    logic [DATA_W-1:0] e;
    #1;
    e = exp_q.pop_front();
    checks++;
    assert (data === e)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, data, e);
    end
  endtask

  // driver tasks
  task automatic set_idle();
    bus.rom_ce_n = 1'b1;
    bus.ram_ce_n = 1'b1;
    bus.ram_we_n = 1'b1;
    bus.ram_oe_n = 1'b1;
    tb_oe        = 1'b0;
  endtask

  task automatic rom_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp, input string tag);
    @(negedge clk);
    set_idle();
    bus.address  = a;
    bus.rom_ce_n = 1'b0;
    push_exp(exp);
    check_bus(tag);
  endtask

  task automatic ram_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp, input string tag);
    @(negedge clk);
    set_idle();
    bus.address  = a;
    bus.ram_ce_n = 1'b0;
    bus.ram_oe_n = 1'b0;
    push_exp(exp);
    check_bus(tag);
  endtask

  task automatic ram_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] v, input logic ce_n);
    @(negedge clk);
    set_idle();
    bus.address  = a;
    bus.ram_ce_n = ce_n;
    bus.ram_we_n = 1'b0;
    tb_wdata     = v;
    tb_oe        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    set_idle();
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.address = '0;
    tb_wdata    = '0;
    set_idle();
    #12;
    rst_n = 1'b1;

    // ROM image
    rom_read(4'd0,  8'h2B, "rom_0");
    rom_read(4'd3,  8'h5B, "rom_3");
    rom_read(4'd7,  8'h3C, "rom_7");
    rom_read(4'd11, 8'h2E, "rom_11");
    rom_read(4'd15, 8'h00, "rom_15");

    // all enables high releases the bus
    @(negedge clk);
    set_idle();
    bus.address = 4'd6;
    push_exp(RELEASED);
    check_bus("idle_z");

    // reset pulse clears every RAM word
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    for (int a = 0; a < DEPTH; a++) begin
      ram_read(a[ADDR_W-1:0], 8'h00, "ram_clear");
    end

    // plain write / read-back, neighbour untouched
    ram_write(4'd4, 8'hA5, 1'b0);
    ram_read(4'd4, 8'hA5, "ram4_a5");
    ram_read(4'd5, 8'h00, "ram5_zero");

    // ROM has priority over an enabled RAM read
    @(negedge clk);
    set_idle();
    bus.address  = 4'd4;
    bus.rom_ce_n = 1'b0;
    bus.ram_ce_n = 1'b0;
    bus.ram_oe_n = 1'b0;
    push_exp(8'h3E);
    check_bus("rom_priority");

    // ROM-to-RAM copy at address 4
    bus.ram_we_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    set_idle();
    ram_read(4'd4, 8'h3E, "ram4_copy");

    // reset releases an active RAM read at once
    @(negedge clk);
    set_idle();
    bus.address  = 4'd4;
    bus.ram_ce_n = 1'b0;
    bus.ram_oe_n = 1'b0;
    push_exp(8'h3E);
    check_bus("ram4_before_rst");
    rst_n = 1'b0;
    push_exp(RELEASED);
    check_bus("rst_release");
    @(negedge clk);
    rst_n = 1'b1;

    // reset between edges aborts a pending write
    @(negedge clk);
    set_idle();
    bus.address  = 4'd2;
    bus.ram_ce_n = 1'b0;
    bus.ram_we_n = 1'b0;
    tb_wdata     = 8'h77;
    tb_oe        = 1'b1;
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    set_idle();
    rst_n = 1'b1;
    ram_read(4'd2, 8'h00, "ram2_abort");
    ram_read(4'd4, 8'h00, "ram4_rst");

    // top address, and a write with the chip deselected
    ram_write(4'd15, 8'hFF, 1'b0);
    ram_read(4'd15, 8'hFF, "ram15_ff");
    ram_write(4'd4, 8'h12, 1'b1);
    ram_read(4'd4, 8'h00, "ram4_no_ce");

    // random writes checked through the same queue
    for (int n = 0; n < 6; n++) begin
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] v;
      a = ADDR_W'($urandom_range(0, DEPTH - 2));
      v = DATA_W'($urandom_range(0, 8'hFE));
      ram_write(a, v, 1'b0);
      ram_read(a, v, "ram_rand");
    end

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL queue_drain: observed %0d expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
